// File: rtl/decode_stage.sv
// Registered MIPS decode stage: valid/ready handshake, load-use bubble, flush,
// and saturating stall / illegal-instruction counters.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned ALU_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_pc_o,
  output logic [RA_W-1:0]  rs_o,
  output logic [RA_W-1:0]  rt_o,
  output logic [RA_W-1:0]  dst_o,
  output logic [XLEN-1:0]  imm_o,
  output logic             write_reg_o,
  output logic             write_mem_o,
  output logic             read_ram_o,
  output logic             use_imm_o,
  output logic             jump_o,
  output logic             jal_o,
  output logic             branch_o,
  output logic             branch_ne_o,
  output logic [ALU_W-1:0] alu_ctrl_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam logic [ALU_W-1:0] ALU_INVALID = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_ADD     = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_SUB     = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_AND     = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_OR      = ALU_W'(4);
  localparam logic [ALU_W-1:0] ALU_SLT     = ALU_W'(5);
  localparam logic [ALU_W-1:0] ALU_LUI     = ALU_W'(6);
  localparam logic [ALU_W-1:0] ALU_PASS_PC = ALU_W'(7);

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_ORI = 6'h0D,
                         OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24,
                         FN_OR = 6'h25, FN_SLT = 6'h2A;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [RA_W-1:0]  rs;
    logic [RA_W-1:0]  rt;
    logic [RA_W-1:0]  dst;
    logic [XLEN-1:0]  imm;
    logic             write_reg;
    logic             write_mem;
    logic             read_ram;
    logic             use_imm;
    logic             jump;
    logic             jal;
    logic             branch;
    logic             branch_ne;
    logic [ALU_W-1:0] alu_ctrl;
    logic             illegal;
  } bundle_t;

  bundle_t          dec, bundle_d, bundle_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] stall_d, stall_q, ill_d, ill_q;
  logic [5:0]       opcode, funct;
  logic             uses_rs, uses_rt, hazard, out_load, accept;
  logic             unused_shamt;

  assign opcode       = instr_i[31:26];
  assign funct        = instr_i[5:0];
  assign unused_shamt = ^instr_i[10:6];

  // Combinational decode of the incoming instruction word.
  always_comb begin
    dec     = '0;
    dec.pc  = pc_i;
    dec.rs  = RA_W'(instr_i[25:21]);
    dec.rt  = RA_W'(instr_i[20:16]);
    uses_rs = ~(opcode == OP_LUI || opcode == OP_J || opcode == OP_JAL);
    uses_rt = (opcode == OP_R || opcode == OP_SW || opcode == OP_BEQ || opcode == OP_BNE);
    case (opcode)
      OP_R: begin
        dec.dst       = RA_W'(instr_i[15:11]);
        dec.write_reg = 1'b1;
        case (funct)
          FN_ADDU: dec.alu_ctrl = ALU_ADD;
          FN_SUBU: dec.alu_ctrl = ALU_SUB;
          FN_AND:  dec.alu_ctrl = ALU_AND;
          FN_OR:   dec.alu_ctrl = ALU_OR;
          FN_SLT:  dec.alu_ctrl = ALU_SLT;
          default: begin
            dec.dst       = '0;
            dec.write_reg = 1'b0;
            dec.illegal   = 1'b1;
          end
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: begin
        dec.dst       = dec.rt;
        dec.imm       = {{(XLEN-16){instr_i[15]}}, instr_i[15:0]};
        dec.use_imm   = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
        dec.write_reg = (opcode != OP_SW);
        dec.read_ram  = (opcode == OP_LW);
        dec.write_mem = (opcode == OP_SW);
      end
      OP_ORI: begin
        dec.dst       = dec.rt;
        dec.imm       = {{(XLEN-16){1'b0}}, instr_i[15:0]};
        dec.use_imm   = 1'b1;
        dec.alu_ctrl  = ALU_OR;
        dec.write_reg = 1'b1;
      end
      OP_LUI: begin
        dec.dst       = dec.rt;
        dec.imm       = XLEN'({instr_i[15:0], 16'h0000});
        dec.use_imm   = 1'b1;
        dec.alu_ctrl  = ALU_LUI;
        dec.write_reg = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec.dst       = dec.rt;
        dec.imm       = {{(XLEN-16){instr_i[15]}}, instr_i[15:0]};
        dec.branch    = 1'b1;
        dec.branch_ne = (opcode == OP_BNE);
        dec.alu_ctrl  = ALU_SUB;
      end
      OP_J, OP_JAL: begin
        dec.imm  = XLEN'({pc_i[XLEN-1 -: 4], instr_i[25:0], 2'b00});
        dec.jump = 1'b1;
        // jal: execute returns pc+8 through PASS_PC into $31
        if (opcode == OP_JAL) begin
          dec.jal       = 1'b1;
          dec.dst       = RA_W'(31);
          dec.write_reg = 1'b1;
          dec.alu_ctrl  = ALU_PASS_PC;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.dst == '0) dec.write_reg = 1'b0;
  end

  assign out_load   = ~valid_q | out_ready_i;
  assign hazard     = valid_q & bundle_q.read_ram & (bundle_q.dst != '0) &
                      ((uses_rs & (dec.rs == bundle_q.dst)) | (uses_rt & (dec.rt == bundle_q.dst)));
  assign in_ready_o = rst_n & ~flush_i & ~hazard & out_load;
  assign accept     = in_valid_i & in_ready_o;

  // Next-state: output register, flush kill and saturating counters.
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    stall_d  = stall_q;
    ill_d    = ill_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (out_load) begin
      valid_d = accept;
      if (accept) bundle_d = dec;
    end
    if (hazard & in_valid_i & ~flush_i & (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (accept & dec.illegal & (ill_q != '1)) ill_d = ill_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      stall_q  <= '0;
      ill_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      stall_q  <= stall_d;
      ill_q    <= ill_d;
    end
  end

  assign out_valid_o   = valid_q;
  assign out_pc_o      = bundle_q.pc;
  assign rs_o          = bundle_q.rs;
  assign rt_o          = bundle_q.rt;
  assign dst_o         = bundle_q.dst;
  assign imm_o         = bundle_q.imm;
  assign write_reg_o   = bundle_q.write_reg;
  assign write_mem_o   = bundle_q.write_mem;
  assign read_ram_o    = bundle_q.read_ram;
  assign use_imm_o     = bundle_q.use_imm;
  assign jump_o        = bundle_q.jump;
  assign jal_o         = bundle_q.jal;
  assign branch_o      = bundle_q.branch;
  assign branch_ne_o   = bundle_q.branch_ne;
  assign alu_ctrl_o    = bundle_q.alu_ctrl;
  assign illegal_o     = bundle_q.illegal;
  assign stall_cnt_o   = stall_q;
  assign illegal_cnt_o = ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: mnemonic-level reference decoder plus a
// transaction model of the one-entry output register and counters.
module tb_decode_stage;

  logic        clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc, out_pc, imm;
  logic [4:0]  rs, rt, dst;
  logic        write_reg, write_mem, read_ram, use_imm, jump, jal, branch, branch_ne, illegal;
  logic [3:0]  alu_ctrl;
  logic [15:0] stall_cnt, illegal_cnt;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc), .flush_i(flush), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_pc_o(out_pc), .rs_o(rs), .rt_o(rt), .dst_o(dst),
    .imm_o(imm), .write_reg_o(write_reg), .write_mem_o(write_mem), .read_ram_o(read_ram),
    .use_imm_o(use_imm), .jump_o(jump), .jal_o(jal), .branch_o(branch),
    .branch_ne_o(branch_ne), .alu_ctrl_o(alu_ctrl), .illegal_o(illegal),
    .stall_cnt_o(stall_cnt), .illegal_cnt_o(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags = {write_reg, write_mem, read_ram, use_imm, jump, jal, branch, branch_ne, illegal}
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs, rt, dst;
    logic [31:0] imm;
    logic [8:0]  flags;
    logic [3:0]  alu;
  } exp_t;

  int n_tests = 0, n_fail = 0;
  bit quiet = 1'b0;
  logic        m_valid;
  exp_t        m_b;
  int          m_stall, m_ill;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic string mnemonic(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'h00: case (fn)
               6'h21: return "addu";
               6'h23: return "subu";
               6'h24: return "and";
               6'h25: return "or";
               6'h2A: return "slt";
               default: return "ill";
             endcase
      6'h02: return "j";
      6'h03: return "jal";
      6'h04: return "beq";
      6'h05: return "bne";
      6'h09: return "addiu";
      6'h0D: return "ori";
      6'h0F: return "lui";
      6'h23: return "lw";
      6'h2B: return "sw";
      default: return "ill";
    endcase
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p);
    exp_t e;
    string m;
    bit writes;
    int sx;
    m = mnemonic(ins);
    sx = int'($signed(ins[15:0]));
    e = '0;
    e.pc = p;
    e.rs = ins[25:21];
    e.rt = ins[20:16];
    writes = 1'b0;
    if (m == "addu" || m == "subu" || m == "and" || m == "or" || m == "slt") begin
      e.dst = ins[15:11];
      writes = 1'b1;
      e.alu = (m == "addu") ? 4'd1 : (m == "subu") ? 4'd2 : (m == "and") ? 4'd3 :
              (m == "or") ? 4'd4 : 4'd5;
    end else if (m == "addiu" || m == "lw" || m == "sw") begin
      e.dst = ins[20:16];
      e.imm = sx;
      e.alu = 4'd1;
      e.flags[5] = 1'b1;
      e.flags[6] = (m == "lw");
      e.flags[7] = (m == "sw");
      writes = (m != "sw");
    end else if (m == "ori") begin
      e.dst = ins[20:16];
      e.imm = 32'(ins[15:0]);
      e.alu = 4'd4;
      e.flags[5] = 1'b1;
      writes = 1'b1;
    end else if (m == "lui") begin
      e.dst = ins[20:16];
      e.imm = 32'(ins[15:0]) * 32'h10000;
      e.alu = 4'd6;
      e.flags[5] = 1'b1;
      writes = 1'b1;
    end else if (m == "beq" || m == "bne") begin
      e.dst = ins[20:16];
      e.imm = sx;
      e.alu = 4'd2;
      e.flags[2] = 1'b1;
      e.flags[1] = (m == "bne");
    end else if (m == "j" || m == "jal") begin
      e.imm = (p & 32'hF000_0000) | (32'(ins[25:0]) * 4);
      e.flags[4] = 1'b1;
      if (m == "jal") begin
        e.dst = 5'd31;
        e.alu = 4'd7;
        e.flags[3] = 1'b1;
        writes = 1'b1;
      end
    end else begin
      e.flags[0] = 1'b1;
    end
    e.flags[8] = writes && (e.dst != 0);
    return e;
  endfunction

  function automatic bit reads_rs(input logic [31:0] ins);
    string m;
    m = mnemonic(ins);
    return !(m == "lui" || m == "j" || m == "jal");
  endfunction

  function automatic bit reads_rt(input logic [31:0] ins);
    string m;
    m = mnemonic(ins);
    return (ins[31:26] == 6'h00) || m == "sw" || m == "beq" || m == "bne";
  endfunction

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("illegal_cnt", 64'(illegal_cnt), 64'(m_ill));
    if (m_valid) begin
      check("out_pc", 64'(out_pc), 64'(m_b.pc));
      check("rs_rt", 64'({rs, rt}), 64'({m_b.rs, m_b.rt}));
      check("dst", 64'(dst), 64'(m_b.dst));
      check("imm", 64'(imm), 64'(m_b.imm));
      check("flags", 64'({write_reg, write_mem, read_ram, use_imm, jump, jal, branch, branch_ne, illegal}),
            64'(m_b.flags));
      check("alu_ctrl", 64'(alu_ctrl), 64'(m_b.alu));
    end
  endtask

  // One clock: drive, check in_ready, advance model, check registered outputs.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic fl, input logic ordy);
    exp_t d;
    bit hz, rdy, acc;
    in_valid = v; instr = ins; pc = p; flush = fl; out_ready = ordy;
    #1;
    d   = ref_decode(ins, p);
    hz  = m_valid && m_b.flags[6] && m_b.dst != 0 &&
          ((reads_rs(ins) && ins[25:21] == m_b.dst) || (reads_rt(ins) && ins[20:16] == m_b.dst));
    rdy = rst_n && !fl && !hz && (!m_valid || ordy);
    acc = v && rdy;
    if (!quiet) check("in_ready", 64'(in_ready), 64'(rdy));
    if (!rst_n) begin
      m_valid = 1'b0; m_b = '0; m_stall = 0; m_ill = 0;
    end else begin
      if (hz && v && !fl && m_stall < 16'hFFFF) m_stall++;
      if (acc && d.flags[0] && m_ill < 16'hFFFF) m_ill++;
      if (fl) m_valid = 1'b0;
      else if (!m_valid || ordy) begin
        m_valid = acc;
        if (acc) m_b = d;
      end
    end
    @(posedge clk);
    #1;
    if (!quiet) check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    logic [15:0] im;
    int k;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    im = 16'($urandom);
    k = $urandom_range(0, 16);
    case (k)
      0: return {6'h00, a, b, c, 5'd0, 6'h21};
      1: return {6'h00, a, b, c, 5'd0, 6'h23};
      2: return {6'h00, a, b, c, 5'd0, 6'h24};
      3: return {6'h00, a, b, c, 5'd0, 6'h25};
      4: return {6'h00, a, b, c, 5'd0, 6'h2A};
      5: return {6'h09, a, b, im};
      6: return {6'h0D, a, b, im};
      7: return {6'h0F, a, b, im};
      8, 9, 10: return {6'h23, a, b, im};
      11: return {6'h2B, a, b, im};
      12: return {6'h04, a, b, im};
      13: return {6'h05, a, b, im};
      14: return {6'h02, 26'($urandom)};
      15: return {6'h03, 26'($urandom)};
      default: return ($urandom_range(0, 1) != 0) ? {6'h3F, 26'($urandom)} : {6'h00, a, b, c, 5'd0, 6'h3E};
    endcase
  endfunction

  localparam logic [31:0] I_ADDU3 = 32'h0022_1821, I_LW5  = 32'h8C25_0004,
                          I_ADDU6 = 32'h00A2_3021, I_ADDIU = 32'h2402_FFFF,
                          I_BNE   = 32'h1422_0003, I_ILL  = 32'hFC00_0000,
                          I_LUI   = 32'h3C04_1234, I_ADDI0 = 32'h2420_0001;

  initial begin
    int guard;
    m_valid = 1'b0; m_b = '0; m_stall = 0; m_ill = 0;
    in_valid = 1'b0; instr = '0; pc = '0; flush = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    step(1'b1, I_ADDU3, 32'h100, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("reset_alu", 64'(alu_ctrl), 64'd0);
    rst_n = 1'b1;

    // addu $3,$1,$2
    step(1'b1, I_ADDU3, 32'h0000_1000, 1'b0, 1'b1);
    check("t1_dst", 64'(dst), 64'd3);
    check("t1_alu", 64'(alu_ctrl), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // lw $5 then dependent addu: one stall, one bubble
    step(1'b1, I_LW5, 32'h0000_2000, 1'b0, 1'b1);
    step(1'b1, I_ADDU6, 32'h0000_2004, 1'b0, 1'b1);
    check("t2_bubble", 64'(out_valid), 64'd0);
    step(1'b1, I_ADDU6, 32'h0000_2004, 1'b0, 1'b1);
    check("t2_addu_dst", 64'(dst), 64'd6);
    check("t2_stall", 64'(stall_cnt), 64'd1);

    // addiu $2,$0,-1 held under backpressure
    step(1'b1, I_ADDIU, 32'h0000_3000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, I_ADDU3, 32'h0000_3004, 1'b0, 1'b0);
    check("t3_imm", 64'(imm), 64'hFFFF_FFFF);
    step(1'b1, I_ADDU3, 32'h0000_3004, 1'b0, 1'b1);

    // flush while bne held and a new instruction offered
    step(1'b1, I_BNE, 32'h0000_4000, 1'b0, 1'b1);
    step(1'b1, I_ADDU3, 32'h0000_4004, 1'b1, 1'b0);
    check("t4_flush_valid", 64'(out_valid), 64'd0);
    step(1'b1, I_ADDU3, 32'h0000_4008, 1'b0, 1'b1);

    // illegal, lui, addiu to $0
    step(1'b1, I_ILL, 32'h0000_5000, 1'b0, 1'b1);
    check("t5_illegal", 64'({illegal, illegal_cnt}), 64'({1'b1, 16'd1}));
    step(1'b1, I_LUI, 32'h0000_5004, 1'b0, 1'b1);
    check("t5_lui_imm", 64'(imm), 64'h1234_0000);
    step(1'b1, I_ADDI0, 32'h0000_5008, 1'b0, 1'b1);
    check("t5_wr0", 64'(write_reg), 64'd0);

    // jal at a high pc
    step(1'b1, 32'h0C00_0040, 32'hA000_0010, 1'b0, 1'b1);

    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0), rand_instr(), {$urandom} & 32'hFFFF_FFFC,
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 7));

    // saturate the stall counter under a held lw
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b1, I_LW5, 32'h0000_6000, 1'b0, 1'b1);
    quiet = 1'b1;
    guard = 0;
    while (m_stall < 16'hFFFF && guard < 70000) begin
      step(1'b1, I_ADDU6, 32'h0000_6004, 1'b0, 1'b0);
      guard++;
    end
    quiet = 1'b0;
    step(1'b1, I_ADDU6, 32'h0000_6004, 1'b0, 1'b0);
    check("t6_stall_sat", 64'(stall_cnt), 64'hFFFF);
    rst_n = 1'b0;
    step(1'b1, I_ADDU6, 32'h0000_6004, 1'b0, 1'b0);
    check("t6_rst_all", 64'({out_valid, stall_cnt, illegal_cnt, dst, alu_ctrl, read_ram}), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 3) != 0), rand_instr(), {$urandom} & 32'hFFFF_FFFC,
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 7));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
